// File: rtl/cpu_gen2_if.sv
// Single request/acknowledge memory port shared by the CPU core (master) and memory (slave).
interface cpu_gen2_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_gen2.sv
// Multicycle memory-to-memory CPU core: fetch, operand fetch, source loads, execute,
// optional store, retire. Every memory access goes through one registered req/ack port.
module cpu_gen2 #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       W_RST,
    cpu_gen2_if.master mem_bus,
    output logic       retire,
    output logic       halted,
    output logic       flag
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] FETCH_W  = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] OPND     = 4'd3;
    localparam logic [3:0] OPND_W   = 4'd4;
    localparam logic [3:0] LOAD_A   = 4'd5;
    localparam logic [3:0] LOAD_A_W = 4'd6;
    localparam logic [3:0] LOAD_B   = 4'd7;
    localparam logic [3:0] LOAD_B_W = 4'd8;
    localparam logic [3:0] EXEC     = 4'd9;
    localparam logic [3:0] STORE    = 4'd10;
    localparam logic [3:0] STORE_W  = 4'd11;
    localparam logic [3:0] RETIRE   = 4'd12;
    localparam logic [3:0] HLT      = 4'd13;

    logic [3:0]        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [3:0]        op_reg;
    logic              cond_reg;
    logic              skip_reg;
    logic [1:0]        cnt_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] res_reg;
    logic              flag_reg;
    logic              halted_reg;
    logic              retire_reg;
    logic              req_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [DATA_W-1:0] opnd [0:2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opnd
            logic [DATA_W-1:0] val_reg;
            always_ff @(posedge clk) begin
                if (state_reg == OPND_W && mem_bus.mem_ack && cnt_reg == 2'(gi))
                    val_reg <= mem_bus.mem_rdata;
            end
            assign opnd[gi] = val_reg;
        end
    endgenerate

    // Operand count and which sources must be loaded, per opcode.
    logic [1:0] nops;
    logic       is_cmp;
    logic       need_a;
    logic       need_b;
    logic       is_store;
    always_comb begin
        nops     = 2'd0;
        is_cmp   = 1'b0;
        need_a   = 1'b0;
        need_b   = 1'b0;
        is_store = 1'b0;
        case (op_reg)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8: begin
                nops = 2'd3; need_a = 1'b1; need_b = 1'b1; is_store = 1'b1;
            end
            4'h5, 4'h9: begin
                nops = 2'd2; need_a = 1'b1; is_store = 1'b1;
            end
            4'hA: begin
                nops = 2'd2; is_store = 1'b1;
            end
            4'hB, 4'hC: begin
                nops = 2'd2; is_cmp = 1'b1; need_a = 1'b1; need_b = 1'b1;
            end
            4'hD:    nops = 2'd1;
            default: nops = 2'd0;
        endcase
    end

    // Compares read M[op0],M[op1]; everything else reads M[op1],M[op2].
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    assign a_addr = is_cmp ? opnd[0][ADDR_W-1:0] : opnd[1][ADDR_W-1:0];
    assign b_addr = is_cmp ? opnd[1][ADDR_W-1:0] : opnd[2][ADDR_W-1:0];

    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W-1:0] alu_res;
    assign sh_amt = b_reg[SH_W-1:0];
    always_comb begin
        alu_res = '0;
        case (op_reg)
            4'h0: alu_res = a_reg + b_reg;
            4'h1: alu_res = a_reg - b_reg;
            4'h2: alu_res = a_reg & b_reg;
            4'h3: alu_res = a_reg | b_reg;
            4'h4: alu_res = a_reg ^ b_reg;
            4'h5: alu_res = ~a_reg;
            4'h6: alu_res = a_reg << sh_amt;
            4'h7: alu_res = a_reg >> sh_amt;
            4'h8: alu_res = $unsigned($signed(a_reg) >>> sh_amt);
            4'h9: alu_res = a_reg;
            4'hA: alu_res = opnd[1];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            op_reg     <= 4'hE;
            cond_reg   <= 1'b0;
            skip_reg   <= 1'b0;
            cnt_reg    <= 2'd0;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            flag_reg   <= 1'b0;
            halted_reg <= 1'b0;
            retire_reg <= 1'b0;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            retire_reg <= 1'b0;
            case (state_reg)
                FETCH: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    addr_reg  <= pc_reg;
                    state_reg <= FETCH_W;
                end
                FETCH_W: if (mem_bus.mem_ack) begin
                    req_reg   <= 1'b0;
                    op_reg    <= mem_bus.mem_rdata[31:28];
                    cond_reg  <= mem_bus.mem_rdata[24];
                    state_reg <= DECODE;
                end
                DECODE: begin
                    skip_reg  <= cond_reg & ~flag_reg;
                    cnt_reg   <= 2'd0;
                    state_reg <= ((cond_reg && !flag_reg) || nops == 2'd0) ? EXEC : OPND;
                end
                OPND: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    addr_reg  <= pc_reg + ADDR_W'(cnt_reg) + ADDR_W'(1);
                    state_reg <= OPND_W;
                end
                OPND_W: if (mem_bus.mem_ack) begin
                    req_reg <= 1'b0;
                    if (cnt_reg == nops - 2'd1) begin
                        cnt_reg   <= 2'd0;
                        state_reg <= need_a ? LOAD_A : EXEC;
                    end else begin
                        cnt_reg   <= cnt_reg + 2'd1;
                        state_reg <= OPND;
                    end
                end
                LOAD_A: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    addr_reg  <= a_addr;
                    state_reg <= LOAD_A_W;
                end
                LOAD_A_W: if (mem_bus.mem_ack) begin
                    req_reg   <= 1'b0;
                    a_reg     <= mem_bus.mem_rdata;
                    state_reg <= need_b ? LOAD_B : EXEC;
                end
                LOAD_B: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b0;
                    addr_reg  <= b_addr;
                    state_reg <= LOAD_B_W;
                end
                LOAD_B_W: if (mem_bus.mem_ack) begin
                    req_reg   <= 1'b0;
                    b_reg     <= mem_bus.mem_rdata;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    res_reg <= alu_res;
                    if (!skip_reg && is_cmp)
                        flag_reg <= (op_reg == 4'hB) ? (a_reg == b_reg)
                                                     : ($signed(a_reg) < $signed(b_reg));
                    if (!skip_reg && is_store) begin
                        state_reg <= STORE;
                    end else begin
                        retire_reg <= 1'b1;
                        state_reg  <= RETIRE;
                    end
                end
                STORE: begin
                    req_reg   <= 1'b1;
                    we_reg    <= 1'b1;
                    addr_reg  <= opnd[0][ADDR_W-1:0];
                    wdata_reg <= res_reg;
                    state_reg <= STORE_W;
                end
                STORE_W: if (mem_bus.mem_ack) begin
                    req_reg    <= 1'b0;
                    we_reg     <= 1'b0;
                    retire_reg <= 1'b1;
                    state_reg  <= RETIRE;
                end
                RETIRE: begin
                    if (!skip_reg && op_reg == 4'hD)
                        pc_reg <= opnd[0][ADDR_W-1:0];
                    else
                        pc_reg <= pc_reg + ADDR_W'(nops) + ADDR_W'(1);
                    if (!skip_reg && op_reg == 4'hF) begin
                        halted_reg <= 1'b1;
                        state_reg  <= HLT;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                HLT:     state_reg <= HLT;
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign mem_bus.mem_req   = req_reg;
    assign mem_bus.mem_we    = we_reg;
    assign mem_bus.mem_addr  = addr_reg;
    assign mem_bus.mem_wdata = wdata_reg;
    assign retire            = retire_reg;
    assign halted            = halted_reg;
    assign flag              = flag_reg;
endmodule

// File: tb/tb_cpu_gen2.sv
// Directed bench for cpu_gen2: a behavioural memory slave with programmable ack delay,
// plus one task per scenario with hand-computed expectations.
module tb_cpu_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic W_RST;
    logic retire;
    logic halted;
    logic flag;

    cpu_gen2_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    cpu_gen2 #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'd0)) dut (
        .clk     (clk),
        .W_RST   (W_RST),
        .mem_bus (bus.master),
        .retire  (retire),
        .halted  (halted),
        .flag    (flag)
    );

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int store_cnt = 0;
    int retire_cnt = 0;
    int wait_cnt = 0;
    int delay = 0;
    int fixed_delay = 0;
    bit rand_mode = 1'b0;
    bit force_ack = 1'b0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;

    function automatic logic [31:0] ins(input logic [3:0] op, input logic c);
        return {op, 3'b000, c, 24'h0};
    endfunction

    // One clock of the memory slave, evaluated at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (p_req && p_ack && !W_RST) begin
            if (p_we) begin
                mem[p_addr[7:0]] = p_wdata;
                store_cnt++;
            end
            acc_cnt++;
            wait_cnt = 0;
            delay = rand_mode ? int'($urandom_range(0, 5)) : fixed_delay;
        end else if (p_req && !W_RST) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        if (p_req && !W_RST && bus.mem_req) begin
            checks++;
            if (p_ack) begin
                errors++;
                $display("FAIL idle_gap: mem_req=%0b at cycle %0d, required 0 after ack", bus.mem_req, cyc);
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {p_we, p_addr, p_wdata}) begin
                errors++;
                $display("FAIL req_stable: we/addr/wdata=%0b/%h/%h, required %0b/%h/%h",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, p_we, p_addr, p_wdata);
            end
        end
        bus.mem_ack   = force_ack | (bus.mem_req && wait_cnt >= delay);
        bus.mem_rdata = mem[bus.mem_addr[7:0]];
        if (retire) begin
            retire_cnt++;
            $display("retire at cycle %0d", cyc);
        end
        p_req   = bus.mem_req;
        p_ack   = bus.mem_ack;
        p_we    = bus.mem_we;
        p_addr  = bus.mem_addr;
        p_wdata = bus.mem_wdata;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        W_RST = 1'b1;
        force_ack = 1'b0;
        wait_cnt = 0;
        delay = fixed_delay;
        tick();
        tick();
        W_RST = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_retire(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!retire && n < 400);
        checks++;
        if (!retire) begin
            errors++;
            $display("FAIL %s_retire_timeout: retire=%0b after %0d cycles, required 1", name, retire, n);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.mem_req && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.mem_req) begin
            errors++;
            $display("FAIL %s_req_timeout: mem_req=%0b, required 1", name, bus.mem_req);
        end
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_timeout: halted=%0b, required 1", name, halted);
        end
    endtask

    task automatic load_add_prog();
        clear_mem();
        mem[0]   = ins(4'h0, 1'b0);
        mem[1]   = 32'd100;
        mem[2]   = 32'd101;
        mem[3]   = 32'd102;
        mem[4]   = ins(4'hF, 1'b0);
        mem[101] = 32'd7;
        mem[102] = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = ins(4'hF, 1'b0);
        W_RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_we, retire, halted, flag} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/retire/halted/flag=%b, required 00000",
                     {bus.mem_req, bus.mem_we, retire, halted, flag});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h, required 0/0", bus.mem_addr, bus.mem_wdata);
        end
        W_RST = 1'b0;
        cyc = 1;
        wait_req("reset");
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_fetch: addr=%h we=%0b, required 0/0", bus.mem_addr, bus.mem_we);
        end
        wait_halt("reset");
    endtask

    task automatic test_add();
        load_add_prog();
        do_reset();
        wait_retire("add");
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL add_latency: retire at cycle %0d, required 17", cyc);
        end
        checks++;
        if (mem[100] !== 32'd6) begin
            errors++;
            $display("FAIL add_result: M[100]=%h, required 00000006", mem[100]);
        end
        wait_req("add");
        checks++;
        if (bus.mem_addr !== 32'd4) begin
            errors++;
            $display("FAIL add_next_pc: fetch addr=%h, required 00000004", bus.mem_addr);
        end
        wait_halt("add");
    endtask

    task automatic test_shift();
        clear_mem();
        mem[0] = ins(4'hA, 1'b0); mem[1] = 32'd50; mem[2] = 32'h8000_0000;
        mem[3] = ins(4'h8, 1'b0); mem[4] = 32'd51; mem[5] = 32'd50; mem[6] = 32'd52;
        mem[7] = ins(4'h7, 1'b0); mem[8] = 32'd53; mem[9] = 32'd50; mem[10] = 32'd52;
        mem[11] = ins(4'hF, 1'b0);
        mem[52] = 32'd4;
        do_reset();
        wait_halt("shift");
        checks++;
        if (mem[50] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ldi_result: M[50]=%h, required 80000000", mem[50]);
        end
        checks++;
        if (mem[51] !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sar_result: M[51]=%h, required f8000000", mem[51]);
        end
        checks++;
        if (mem[53] !== 32'h0800_0000) begin
            errors++;
            $display("FAIL shr_result: M[53]=%h, required 08000000", mem[53]);
        end
    endtask

    task automatic test_alu();
        logic [31:0] exp_val [0:6];
        clear_mem();
        mem[200] = 32'h0000_000A;
        mem[201] = 32'hFFFF_FFFD;
        mem[202] = 32'h0000_0023;
        mem[0]  = ins(4'h1, 1'b0); mem[1]  = 32'd210; mem[2]  = 32'd200; mem[3]  = 32'd201;
        mem[4]  = ins(4'h2, 1'b0); mem[5]  = 32'd211; mem[6]  = 32'd200; mem[7]  = 32'd201;
        mem[8]  = ins(4'h3, 1'b0); mem[9]  = 32'd212; mem[10] = 32'd200; mem[11] = 32'd202;
        mem[12] = ins(4'h4, 1'b0); mem[13] = 32'd213; mem[14] = 32'd200; mem[15] = 32'd201;
        mem[16] = ins(4'h5, 1'b0); mem[17] = 32'd214; mem[18] = 32'd200;
        mem[19] = ins(4'h9, 1'b0); mem[20] = 32'd215; mem[21] = 32'd201;
        mem[22] = ins(4'h6, 1'b0); mem[23] = 32'd216; mem[24] = 32'd200; mem[25] = 32'd202;
        mem[26] = ins(4'hC, 1'b0); mem[27] = 32'd201; mem[28] = 32'd200;
        mem[29] = ins(4'hF, 1'b0);
        exp_val[0] = 32'h0000_000D;
        exp_val[1] = 32'h0000_0008;
        exp_val[2] = 32'h0000_002B;
        exp_val[3] = 32'hFFFF_FFF7;
        exp_val[4] = 32'hFFFF_FFF5;
        exp_val[5] = 32'hFFFF_FFFD;
        exp_val[6] = 32'h0000_0050;
        do_reset();
        wait_halt("alu");
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (mem[210 + i] !== exp_val[i]) begin
                errors++;
                $display("FAIL alu_op%0d: M[%0d]=%h, required %h", i, 210 + i, mem[210 + i], exp_val[i]);
            end
        end
        checks++;
        if (flag !== 1'b1) begin
            errors++;
            $display("FAIL cmplt_flag: flag=%0b, required 1", flag);
        end
    endtask

    task automatic test_cond_jmp();
        int c0;
        int a0;
        clear_mem();
        mem[0] = ins(4'hB, 1'b0); mem[1] = 32'd60; mem[2] = 32'd61;
        mem[3] = ins(4'hD, 1'b1); mem[4] = 32'h20;
        mem[5] = ins(4'hF, 1'b0);
        mem[32] = ins(4'hF, 1'b0);
        mem[60] = 32'd5;
        mem[61] = 32'd5;
        do_reset();
        wait_retire("cmpeq");
        checks++;
        if (flag !== 1'b1) begin
            errors++;
            $display("FAIL cmpeq_flag: flag=%0b, required 1", flag);
        end
        c0 = cyc;
        wait_retire("jmp_taken");
        checks++;
        if (cyc - c0 !== 7) begin
            errors++;
            $display("FAIL jmp_latency: %0d cycles, required 7", cyc - c0);
        end
        wait_req("jmp_taken");
        checks++;
        if (bus.mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL jmp_target: fetch addr=%h, required 00000020", bus.mem_addr);
        end
        wait_halt("jmp_taken");

        mem[61] = 32'd6;
        do_reset();
        wait_retire("cmpne");
        checks++;
        if (flag !== 1'b0) begin
            errors++;
            $display("FAIL cmpeq_clear: flag=%0b, required 0", flag);
        end
        c0 = cyc;
        a0 = acc_cnt;
        wait_retire("jmp_skip");
        checks++;
        if (cyc - c0 !== 5) begin
            errors++;
            $display("FAIL skip_latency: %0d cycles, required 5", cyc - c0);
        end
        checks++;
        if (acc_cnt - a0 !== 1) begin
            errors++;
            $display("FAIL skip_accesses: %0d accesses, required 1", acc_cnt - a0);
        end
        wait_req("jmp_skip");
        checks++;
        if (bus.mem_addr !== 32'd5) begin
            errors++;
            $display("FAIL skip_next_pc: fetch addr=%h, required 00000005", bus.mem_addr);
        end
        wait_halt("jmp_skip");
    endtask

    task automatic test_wait_states();
        load_add_prog();
        rand_mode = 1'b1;
        do_reset();
        wait_retire("wait_add");
        checks++;
        if (mem[100] !== 32'd6) begin
            errors++;
            $display("FAIL wait_add_result: M[100]=%h, required 00000006", mem[100]);
        end
        wait_req("wait_add");
        checks++;
        if (bus.mem_addr !== 32'd4) begin
            errors++;
            $display("FAIL wait_add_next_pc: fetch addr=%h, required 00000004", bus.mem_addr);
        end
        wait_halt("wait_add");
        rand_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int s0;
        load_add_prog();
        fixed_delay = 3;
        do_reset();
        while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == 32'd101) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (!(bus.mem_req && bus.mem_addr == 32'd101)) begin
            errors++;
            $display("FAIL load_a_seen: req=%0b addr=%h, required 1/00000065", bus.mem_req, bus.mem_addr);
        end
        s0 = store_cnt;
        W_RST = 1'b1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_req: mem_req=%0b, required 0", bus.mem_req);
        end
        tick();
        W_RST = 1'b0;
        force_ack = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_refetch: req=%0b addr=%h we=%0b, required 1/00000000/0",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        checks++;
        if (store_cnt !== s0 || mem[100] !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_store: stores=%0d M[100]=%h, required %0d/00000000",
                     store_cnt, mem[100], s0);
        end
        fixed_delay = 0;
        wait_retire("reset_mid");
        checks++;
        if (mem[100] !== 32'd6) begin
            errors++;
            $display("FAIL reset_rerun_result: M[100]=%h, required 00000006", mem[100]);
        end
        wait_halt("reset_mid");
    endtask

    task automatic test_halt();
        int r0;
        int reqs = 0;
        int rets = 0;
        clear_mem();
        mem[0] = ins(4'hA, 1'b0); mem[1] = 32'd70; mem[2] = 32'h0000_1234;
        mem[3] = ins(4'hE, 1'b0);
        mem[4] = ins(4'hE, 1'b0);
        mem[5] = ins(4'hF, 1'b0);
        do_reset();
        r0 = retire_cnt;
        wait_retire("ldi");
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL ldi_latency: retire at cycle %0d, required 11", cyc);
        end
        wait_halt("halt");
        checks++;
        if (retire_cnt - r0 !== 4) begin
            errors++;
            $display("FAIL halt_retires: %0d retire pulses, required 4", retire_cnt - r0);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.mem_req) reqs++;
            if (retire) rets++;
        end
        checks++;
        if (reqs !== 0 || rets !== 0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_quiet: reqs=%0d retires=%0d halted=%0b, required 0/0/1", reqs, rets, halted);
        end
        checks++;
        if (mem[70] !== 32'h0000_1234) begin
            errors++;
            $display("FAIL halt_ldi_result: M[70]=%h, required 00001234", mem[70]);
        end
        W_RST = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halted=%0b, required 0", halted);
        end
        W_RST = 1'b0;
    endtask

    initial begin
        W_RST = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_add();
        test_shift();
        test_alu();
        test_cond_jmp();
        test_wait_states();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_gen2.md
Name: cpu_gen2

Overview:
- Parametrised multicycle memory-to-memory CPU core and the successor to the fixed 32-bit core.
- Fetches one instruction word followed by 0–3 operand words, then loads source data, executes, and optionally stores the result.
- Talks directly to a single request/acknowledge memory port, with no separate fetch unit.
- Adds parameterised width, a compare flag, conditional execution, jump, load-immediate, halt and a retire strobe.

Parameters:
- DATA_W, 32, datapath and memory word width; must be ≥32.
- ADDR_W, 32, word-address width; must be ≤DATA_W. Address operands use their low ADDR_W bits.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  core clock.
- W_RST  in  1  synchronous active-high reset.
- mem_req  out  1  access request; held until acked.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data; valid when mem_ack is high.
- mem_ack  in  1  access complete; only meaningful while mem_req is high.
- retire  out  1  one-cycle pulse when an instruction completes, including skipped instructions.
- halted  out  1  high after HALT executes.
- flag  out  1  compare flag.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset W_RST is synchronous and active-high.
  - Values on reset: PC=RESET_PC, state=FETCH, flag=0, halted=0, retire=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-access drops mem_req on the next edge. Any ack arriving after reset is ignored.
- Memory handshake:
  - All outputs are registered.
  - mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the cycle mem_ack=1 is sampled.
  - mem_req deasserts on the following edge. Back-to-back requests always have ≥1 idle cycle between them.
  - With a slave that acks in the first cycle of mem_req, one access costs 2 cycles.
- Instruction word fields:
  - [31:28] opcode.
  - [24] cond: when set and flag=0, the instruction is skipped.
  - All other bits are ignored.
- Operand words: op0, op1, op2 sit at PC+1, PC+2, PC+3.
- Opcode set:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: 3 operands; M[op0] <= M[op1] op M[op2].
  - 6 SHL, 7 SHR (logical), 8 SAR: 3 operands; shift amount = M[op2][clog2(DATA_W)-1:0].
  - 5 NOT: 2 operands; M[op0] <= ~M[op1].
  - 9 MOV: 2 operands; M[op0] <= M[op1].
  - A LDI: 2 operands; M[op0] <= op1, with no data load.
  - B CMPEQ: 2 operands; flag <= (M[op0]==M[op1]); no store.
  - C CMPLT: 2 operands; flag <= signed M[op0] < M[op1]; no store.
  - D JMP: 1 operand; PC <= op0.
  - F HALT: 0 operands.
  - E and any other value: NOP, 0 operands.
- Arithmetic:
  - All arithmetic is modulo 2^DATA_W.
  - SUB is op1 minus op2.
  - Shifts ≥ DATA_W cannot occur because of the shift-amount mask.
- State machine:
  - FETCH → FETCH_W (capture instr) → DECODE.
  - DECODE goes to EXEC if skipped or the operand count is 0; otherwise to OPND.
  - OPND/OPND_W loop once per operand word, with a 2-bit counter.
  - Then LOAD_A/LOAD_A_W for the first source, then LOAD_B/LOAD_B_W for the second source, each only if that source is needed, then EXEC.
  - EXEC goes to STORE/STORE_W for store ops, then RETIRE; otherwise directly to RETIRE.
  - RETIRE pulses retire, updates PC, and returns to FETCH. After HALT it goes to HLT instead.
- PC update:
  - Normal: PC <= PC + 1 + nops.
  - Skipped instructions advance by their full operand count and are not fetched.
  - Taken JMP: PC <= op0.
  - PC wraps modulo 2^ADDR_W, including for operand addresses PC+k.
- Latency, with 1-cycle-ack memory: cycles = 2×accesses + 3 (DECODE, EXEC, RETIRE).
  - ADD: 7 accesses → 17 cycles.
  - LDI: 4 accesses → 11 cycles.
  - JMP: 2 accesses → 7 cycles.
  - Skipped: 1 access → 5 cycles.
- HLT state:
  - No further requests.
  - halted=1 and retire=0 until reset.
- Wait states: arbitrarily long ack delay stretches only the corresponding *_W state; no other state changes.

Test Plan:
- Reset PC=0. Mem: 0:ADD, 1:100, 2:101, 3:102; M[101]=7, M[102]=0xFFFFFFFF. Required: M[100]=6, retire 17 cycles after reset release, PC=4.
- LDI M[50]=0x8000_0000, then SAR M[51]=M[50] by M[52]=4. Required: M[51]=0xF800_0000. SHR variant gives 0x0800_0000.
- CMPEQ on equal values sets flag=1. Conditional JMP to 0x20 is taken, next fetch mem_addr=0x20. With flag=0 the JMP is skipped: PC += 2 and only one access occurs.
- Slave with random 0–5 cycle ack delay runs the same ADD program. Required: results identical, mem_req/addr/we stable until ack, ≥1 idle cycle between requests.
- W_RST pulsed during LOAD_A_W. Required: mem_req low the next cycle, PC=RESET_PC, no store issued, a late ack ignored, next request is a fetch at RESET_PC.
- HALT at address 5. Required: halted=1, no mem_req thereafter for 100 cycles, retire pulses exactly once for the HALT.
